// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline: tracks EX/MEM/WB
// register usage and drives stall, bubble, flush, forwarding selects and event counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  ex_branch_taken_i,
  output logic                  stall_o,
  output logic                  id_ex_bubble_o,
  output logic                  flush_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);
  typedef logic [REG_ADDR_W-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    reg_t rs1;
    reg_t rs2;
    logic rs1_used;
    logic rs2_used;
    logic reg_write;
    logic mem_read;
  } ex_stage_t;

  // Once past EX only the destination matters to later consumers.
  typedef struct packed {
    logic valid;
    reg_t rd;
    logic reg_write;
  } ret_stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_stage_t  ex_q;
  ret_stage_t mem_q, wb_q;
  logic       hazard;

  function automatic logic prod_ex(ex_stage_t s, reg_t r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

  function automatic logic prod_ret(ret_stage_t s, reg_t r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(logic used, reg_t r, ret_stage_t m, ret_stage_t w);
    if (!FWD_EN || !used) return 2'b00;
    if (prod_ret(m, r))   return 2'b01;
    if (prod_ret(w, r))   return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    hazard = 1'b0;
    if (id_valid_i) begin
      if (FWD_EN)
        hazard = ex_q.mem_read &&
                 ((id_rs1_used_i && prod_ex(ex_q, id_rs1_i)) ||
                  (id_rs2_used_i && prod_ex(ex_q, id_rs2_i)));
      else
        hazard = (id_rs1_used_i && (prod_ex(ex_q, id_rs1_i) || prod_ret(mem_q, id_rs1_i) ||
                                    prod_ret(wb_q, id_rs1_i))) ||
                 (id_rs2_used_i && (prod_ex(ex_q, id_rs2_i) || prod_ret(mem_q, id_rs2_i) ||
                                    prod_ret(wb_q, id_rs2_i)));
    end
  end

  // Gated by reset so every control output is quiet while reset is held.
  assign flush_o        = ex_branch_taken_i & reset;
  assign stall_o        = hazard & ~flush_o;
  assign id_ex_bubble_o = stall_o | flush_o;
  assign fwd_a_sel_o    = fwd_sel(ex_q.rs1_used, ex_q.rs1, mem_q, wb_q);
  assign fwd_b_sel_o    = fwd_sel(ex_q.rs2_used, ex_q.rs2, mem_q, wb_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      if (id_valid_i && !stall_o && !flush_o)
        ex_q <= '{valid: 1'b1, rd: id_rd_i, rs1: id_rs1_i, rs2: id_rs2_i,
                  rs1_used: id_rs1_used_i, rs2_used: id_rs2_used_i,
                  reg_write: id_reg_write_i, mem_read: id_mem_read_i};
      else
        ex_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && stall_cnt_o != CNT_MAX) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_o && flush_cnt_o != CNT_MAX) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Three controllers (forwarding, stall-only, 4-bit counters) on shared ID inputs,
// compared against an in-flight instruction history model.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, branch;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall_w[3], flush_w[3], bub_w[3];
  logic [1:0]  fa_w[3], fb_w[3];
  logic [15:0] scnt[3], fcnt[3];
  logic [3:0]  sc4, fc4;
  assign scnt[2] = {12'b0, sc4};
  assign fcnt[2] = {12'b0, fc4};

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
    .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .ex_branch_taken_i(branch),
    .stall_o(stall_w[0]), .id_ex_bubble_o(bub_w[0]), .flush_o(flush_w[0]),
    .fwd_a_sel_o(fa_w[0]), .fwd_b_sel_o(fb_w[0]), .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0]));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
    .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .ex_branch_taken_i(branch),
    .stall_o(stall_w[1]), .id_ex_bubble_o(bub_w[1]), .flush_o(flush_w[1]),
    .fwd_a_sel_o(fa_w[1]), .fwd_b_sel_o(fb_w[1]), .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1]));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .id_rd_i(id_rd),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read), .ex_branch_taken_i(branch),
    .stall_o(stall_w[2]), .id_ex_bubble_o(bub_w[2]), .flush_o(flush_w[2]),
    .fwd_a_sel_o(fa_w[2]), .fwd_b_sel_o(fb_w[2]), .stall_cnt_o(sc4), .flush_cnt_o(fc4));

  typedef struct {
    bit       v;
    bit [4:0] rd, rs1, rs2;
    bit       u1, u2, rw, mr;
  } ins_t;

  localparam bit          FWD[3]  = '{1'b1, 1'b0, 1'b1};
  localparam int unsigned CMAX[3] = '{65535, 65535, 15};

  // hq[i][0] is the oldest in-flight instruction (WB), hq[i][2] the newest (EX).
  ins_t        hq[3][$];
  int unsigned m_scnt[3], m_fcnt[3];
  bit          e_stall[3], e_flush[3];
  int          vectors = 0;
  int          fails = 0;
  int unsigned base;

  function automatic bit prod(ins_t s, bit [4:0] r);
    return s.v && s.rw && s.rd == r && r != 0;
  endfunction

  function automatic bit [1:0] fsel(bit f, bit u, bit [4:0] r, ins_t mem, ins_t wb);
    if (!f || !u) return 2'd0;
    if (prod(mem, r)) return 2'd1;
    if (prod(wb, r)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ins_t b;
    b = '{default: 0};
    for (int i = 0; i < 3; i++) begin
      hq[i].delete();
      for (int k = 0; k < 3; k++) hq[i].push_back(b);
      m_scnt[i] = 0;
      m_fcnt[i] = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      bit haz;
      haz = 1'b0;
      if (id_valid) begin
        if (FWD[i])
          haz = hq[i][2].mr && ((id_rs1_used && prod(hq[i][2], id_rs1)) ||
                                (id_rs2_used && prod(hq[i][2], id_rs2)));
        else
          for (int k = 0; k < 3; k++)
            if ((id_rs1_used && prod(hq[i][k], id_rs1)) || (id_rs2_used && prod(hq[i][k], id_rs2)))
              haz = 1'b1;
      end
      e_flush[i] = branch && reset;
      e_stall[i] = haz && !e_flush[i];
      chk($sformatf("u%0d_stall", i), 32'(stall_w[i]), 32'(e_stall[i]));
      chk($sformatf("u%0d_flush", i), 32'(flush_w[i]), 32'(e_flush[i]));
      chk($sformatf("u%0d_bubble", i), 32'(bub_w[i]), 32'(e_stall[i] || e_flush[i]));
      chk($sformatf("u%0d_fwd_a", i), 32'(fa_w[i]),
          32'(fsel(FWD[i], hq[i][2].u1, hq[i][2].rs1, hq[i][1], hq[i][0])));
      chk($sformatf("u%0d_fwd_b", i), 32'(fb_w[i]),
          32'(fsel(FWD[i], hq[i][2].u2, hq[i][2].rs2, hq[i][1], hq[i][0])));
      chk($sformatf("u%0d_stall_cnt", i), 32'(scnt[i]), m_scnt[i]);
      chk($sformatf("u%0d_flush_cnt", i), 32'(fcnt[i]), m_fcnt[i]);
    end
  endtask

  // Inputs are set just after a falling edge; check, clock, then advance the model.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        ins_t n;
        n = '{default: 0};
        if (id_valid && !e_stall[i] && !e_flush[i]) begin
          n.v = 1; n.rd = id_rd; n.rs1 = id_rs1; n.rs2 = id_rs2;
          n.u1 = id_rs1_used; n.u2 = id_rs2_used; n.rw = id_reg_write; n.mr = id_mem_read;
        end
        hq[i].push_back(n);
        void'(hq[i].pop_front());
        if (e_stall[i] && m_scnt[i] < CMAX[i]) m_scnt[i]++;
        if (e_flush[i] && m_fcnt[i] < CMAX[i]) m_fcnt[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_id(bit v, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                        bit u1, bit u2, bit rw, bit mr);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_used = u1; id_rs2_used = u2; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    branch = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    step();
    reset = 1;

    // addi x5,x0,7 ; add x6,x5,x5 ; add x7,x5,x6
    set_id(1, 5, 0, 0, 1, 0, 1, 0); step();
    set_id(1, 6, 5, 5, 1, 1, 1, 0);
    #1 chk("fw_no_stall", 32'(stall_w[0]), 0);
    step();
    set_id(1, 7, 5, 6, 1, 1, 1, 0);
    #1 chk("fw_x6_a", 32'(fa_w[0]), 1);
    chk("fw_x6_b", 32'(fb_w[0]), 1);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("fw_x7_a", 32'(fa_w[0]), 2);
    chk("fw_x7_b", 32'(fb_w[0]), 1);
    chk("fw_stall_cnt", 32'(scnt[0]), 0);
    step();
    drain();

    // lw x5,0(x0) ; add x6,x5,x0
    set_id(1, 5, 0, 0, 1, 0, 1, 1); step();
    set_id(1, 6, 5, 0, 1, 1, 1, 0);
    #1 chk("lu_stall", 32'(stall_w[0]), 1);
    chk("lu_bubble", 32'(bub_w[0]), 1);
    step();
    #1 chk("lu_release", 32'(stall_w[0]), 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lu_fwd_a", 32'(fa_w[0]), 2);
    chk("lu_stall_cnt", 32'(scnt[0]), 1);
    step();
    drain();

    // addi x0,x0,1 ; add x6,x0,x0
    set_id(1, 0, 0, 0, 1, 0, 1, 0); step();
    set_id(1, 6, 0, 0, 1, 1, 1, 0);
    #1 chk("x0_stall_fwd", 32'(stall_w[0]), 0);
    chk("x0_stall_nofwd", 32'(stall_w[1]), 0);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("x0_fwd_a", 32'(fa_w[0]), 0);
    chk("x0_fwd_b", 32'(fb_w[0]), 0);
    step();
    drain();

    // Branch taken while a load-use hazard sits in ID
    set_id(1, 5, 0, 0, 1, 0, 1, 1); step();
    set_id(1, 6, 5, 0, 1, 1, 1, 0);
    branch = 1;
    #1 chk("sim_flush", 32'(flush_w[0]), 1);
    chk("sim_stall", 32'(stall_w[0]), 0);
    chk("sim_bubble", 32'(bub_w[0]), 1);
    step();
    branch = 0;
    #1 chk("sim_after_stall", 32'(stall_w[0]), 0);
    chk("sim_flush_cnt", 32'(fcnt[0]), 1);
    chk("sim_stall_cnt", 32'(scnt[0]), 1);
    step();
    drain();

    // Stall-only: addi x5,x0,3 ; add x6,x5,x0
    set_id(1, 5, 0, 0, 1, 0, 1, 0); step();
    set_id(1, 6, 5, 0, 1, 1, 1, 0);
    base = m_scnt[1];
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("so_stall%0d", k), 32'(stall_w[1]), (k < 3) ? 1 : 0);
      if (k == 3) chk("so_stall_cnt", 32'(scnt[1]), base + 3);
      step();
    end
    drain();

    for (int n = 0; n < 300; n++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      branch = ($urandom_range(0, 7) == 0);
      step();
    end
    branch = 0;
    drain();

    branch = 1;
    for (int k = 0; k < 20; k++) step();
    branch = 0;
    #1 chk("sat_flush_cnt", 32'(fcnt[2]), 15);
    step();
    drain();

    // Reset asserted in the middle of a load-use stall
    set_id(1, 5, 0, 0, 1, 0, 1, 1); step();
    set_id(1, 6, 5, 0, 1, 1, 1, 0);
    #1 chk("rst_pre_stall", 32'(stall_w[0]), 1);
    reset = 0;
    branch = 1;
    #1 for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_u%0d_stall", i), 32'(stall_w[i]), 0);
      chk($sformatf("rst_u%0d_flush", i), 32'(flush_w[i]), 0);
      chk($sformatf("rst_u%0d_cnt", i), 32'(scnt[i]) + 32'(fcnt[i]), 0);
    end
    model_reset();
    step();
    reset = 1;
    branch = 0;
    #1 chk("rst_post_stall", 32'(stall_w[0]), 0);
    chk("rst_post_cnt", 32'(fcnt[0]), 0);
    step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
